// File: rtl/location_info_controller_pkg.sv
// Shared definitions for the location-information memory: walk FSM states and
// the layout of one memory line as seen by the live-in/live-out consumers.
package location_info_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } lim_state_e;

    localparam int LIM_PE_SEL_W  = 6;
    localparam int LIM_RF_ADDR_W = 5;
    localparam int LIM_VIA_W     = 6;
    localparam int LIM_MUX_W     = 8;
    localparam int LIM_LINE_W    = LIM_PE_SEL_W + LIM_RF_ADDR_W + LIM_VIA_W + LIM_MUX_W;

    typedef struct packed {
        logic [LIM_PE_SEL_W-1:0]  pe_sel;
        logic [LIM_RF_ADDR_W-1:0] rf_addr;
        logic [LIM_VIA_W-1:0]     via;
        logic [LIM_MUX_W-1:0]     mux;
    } lim_line_t;

    function automatic lim_line_t lim_unpack(input logic [LIM_LINE_W-1:0] raw);
        return lim_line_t'(raw);
    endfunction

endpackage

// File: rtl/lim_addr_gen.sv
// Walk address generator: holds base and entry index, and produces the memory
// read address (external base while idle, base+idx or base+idx+1 while walking).
module lim_addr_gen #(
    parameter int ADDR_WIDTH  = 9,
    parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   load_i,
    input  logic [ADDR_WIDTH-1:0]  base_i,
    input  logic                   advance_i,
    input  logic                   step_i,
    input  logic                   use_base_i,
    output logic [ADDR_WIDTH-1:0]  rd_addr_o,
    output logic [COUNT_WIDTH-1:0] idx_o
);

    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]  walk_addr;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        base_d = base_q;
        idx_d  = idx_q;
        if (load_i) begin
            base_d = base_i;
            idx_d  = '0;
        end else if (advance_i) begin
            idx_d = idx_q + COUNT_WIDTH'(1);
        end
    end

    // Sum truncates to ADDR_WIDTH, so a walk past the top line wraps to line 0.
    assign walk_addr = base_q + idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(step_i);
    assign rd_addr_o = use_base_i ? base_i : walk_addr;
    assign idx_o     = idx_q;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n_i) begin
            base_q <= '0;
            idx_q  <= '0;
        end else begin
            base_q <= base_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/location_info_controller.sv
// Sequencer and port owner for the location-information memory: accepts host
// line writes while idle and streams count entries from base with valid/ready.
module location_info_controller
    import location_info_controller_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int MEM_WIDTH   = LIM_LINE_W,
    parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cfg_valid_i,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr_i,
    input  logic [MEM_WIDTH-1:0]   cfg_data_i,
    output logic                   cfg_ready_o,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  base_addr_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr_o,
    output logic [ADDR_WIDTH-1:0]  mem_wr_addr_o,
    output logic [MEM_WIDTH-1:0]   mem_wr_data_o,
    output logic                   mem_wr_en_o,
    output logic                   entry_valid_o,
    input  logic                   entry_ready_i,
    output logic                   entry_last_o,
    output logic [COUNT_WIDTH-1:0] entry_index_o
);

    lim_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [MEM_WIDTH-1:0]   wr_data_q;

    logic                   load, advance, step, use_base, is_last;
    logic [COUNT_WIDTH-1:0] idx;

    lim_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (load),
        .base_i    (base_addr_i),
        .advance_i (advance),
        .step_i    (step),
        .use_base_i(use_base),
        .rd_addr_o (mem_rd_addr_o),
        .idx_o     (idx)
    );

    assign is_last = (idx == count_q - COUNT_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        cfg_ready_o   = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        entry_valid_o = 1'b0;
        entry_last_o  = 1'b0;
        load          = 1'b0;
        advance       = 1'b0;
        step          = 1'b0;
        use_base      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                use_base    = 1'b1;
                cfg_ready_o = ~start_i;
                if (start_i) begin
                    load    = 1'b1;
                    count_d = count_i;
                    state_d = (count_i == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy_o        = 1'b1;
                entry_valid_o = 1'b1;
                entry_last_o  = is_last;
                // Memory reloads every clock: read ahead on a handshake, re-read while stalled.
                step          = entry_ready_i;
                if (entry_ready_i) begin
                    if (is_last) state_d = ST_DONE;
                    else         advance = 1'b1;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        wr_en_d = cfg_valid_i & cfg_ready_o;
    end

    assign entry_index_o = idx;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = wr_addr_q;
    assign mem_wr_data_o = wr_data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
        end
    end

    // NOTE: write address/data are qualified by wr_en_q, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_d) begin
            wr_addr_q <= cfg_addr_i;
            wr_data_q <= cfg_data_i;
        end
    end

endmodule

// File: tb/tb_location_info_controller.sv
// Directed bench for location_info_controller with a one-cycle-latency memory
// model attached to its read and write ports.
module tb_location_info_controller;

    localparam int AW = 9;
    localparam int MW = 25;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic [AW-1:0] cfg_addr;
    logic [MW-1:0] cfg_data;
    logic          cfg_ready;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] count;
    logic          busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [MW-1:0] wr_data;
    logic          wr_en;
    logic          entry_valid, entry_ready, entry_last;
    logic [CW-1:0] entry_index;

    logic [MW-1:0] mem [512];
    logic [MW-1:0] rd_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    location_info_controller #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW), .COUNT_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cfg_valid_i  (cfg_valid),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .cfg_ready_o  (cfg_ready),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .count_i      (count),
        .busy_o       (busy),
        .done_o       (done),
        .mem_rd_addr_o(rd_addr),
        .mem_wr_addr_o(wr_addr),
        .mem_wr_data_o(wr_data),
        .mem_wr_en_o  (wr_en),
        .entry_valid_o(entry_valid),
        .entry_ready_i(entry_ready),
        .entry_last_o (entry_last),
        .entry_index_o(entry_index)
    );

    task automatic cfg_write(input logic [AW-1:0] a, input logic [MW-1:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== a || wr_data !== d) begin
            errors++;
            $display("FAIL cfg_write: got en=%b addr=%0d data=%0h want en=1 addr=%0d data=%0h",
                     wr_en, wr_addr, wr_data, a, d);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic start_walk(input logic [AW-1:0] b, input logic [CW-1:0] c);
        start = 1'b1; base_addr = b; count = c;
        #1;
        checks++;
        if (rd_addr !== b || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_walk: got rd_addr=%0d cfg_ready=%b want rd_addr=%0d cfg_ready=0",
                     rd_addr, cfg_ready, b);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; base_addr = '0; count = '0; entry_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({busy, done, entry_valid, entry_last, wr_en} !== 5'b0 || entry_index !== '0
            || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b last=%b wr_en=%b idx=%0d ready=%b want all 0, ready=1",
                     busy, done, entry_valid, entry_last, wr_en, entry_index, cfg_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        logic [MW-1:0] lines [4] = '{25'h0A, 25'h0B, 25'h0C, 25'h0D};
        for (int i = 0; i < 4; i++) cfg_write(AW'(i), lines[i]);
        @(negedge clk);
    endtask

    task automatic test_basic_walk();
        logic [MW-1:0] exp [4] = '{25'h0A, 25'h0B, 25'h0C, 25'h0D};
        entry_ready = 1'b1;
        start_walk(9'd0, 10'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (entry_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rd_q !== exp[i]
                || entry_index !== CW'(i) || entry_last !== (i == 3) || rd_addr !== AW'(i + 1)) begin
                errors++;
                $display("FAIL basic_entry%0d: got v=%b data=%0h idx=%0d last=%b rd_addr=%0d want v=1 data=%0h idx=%0d last=%b rd_addr=%0d",
                         i, entry_valid, rd_q, entry_index, entry_last, rd_addr, exp[i], i, (i == 3), i + 1);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || entry_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: got done=%b valid=%b busy=%b want 1 0 1", done, entry_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        logic [MW-1:0] exp [4] = '{25'h0A, 25'h0B, 25'h0C, 25'h0D};
        logic          rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int            eidx [6] = '{0, 1, 1, 1, 2, 3};
        start_walk(9'd0, 10'd4);
        for (int c = 0; c < 6; c++) begin
            entry_ready = rdy[c];
            #1;
            checks++;
            if (entry_valid !== 1'b1 || entry_index !== CW'(eidx[c]) || rd_q !== exp[eidx[c]]
                || rd_addr !== AW'(eidx[c] + int'(rdy[c])) || entry_last !== (eidx[c] == 3)) begin
                errors++;
                $display("FAIL stall_cycle%0d: got v=%b idx=%0d data=%0h rd_addr=%0d last=%b want v=1 idx=%0d data=%0h rd_addr=%0d last=%b",
                         c, entry_valid, entry_index, rd_q, rd_addr, entry_last,
                         eidx[c], exp[eidx[c]], eidx[c] + int'(rdy[c]), (eidx[c] == 3));
            end
            @(negedge clk);
        end
        entry_ready = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL stall_done: got done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [MW-1:0] exp [4] = '{25'h15, 25'h16, 25'h0A, 25'h0B};
        logic [AW-1:0] nxt [4] = '{9'd511, 9'd0, 9'd1, 9'd2};
        cfg_write(9'd510, 25'h15);
        cfg_write(9'd511, 25'h16);
        @(negedge clk);
        entry_ready = 1'b1;
        start_walk(9'd510, 10'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (entry_valid !== 1'b1 || rd_q !== exp[i] || rd_addr !== nxt[i]
                || entry_index !== CW'(i)) begin
                errors++;
                $display("FAIL wrap_entry%0d: got v=%b data=%0h rd_addr=%0d idx=%0d want v=1 data=%0h rd_addr=%0d idx=%0d",
                         i, entry_valid, rd_q, rd_addr, entry_index, exp[i], nxt[i], i);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL wrap_done: got done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        start_walk(9'd3, 10'd0);
        checks++;
        if (done !== 1'b1 || entry_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got done=%b valid=%b busy=%b want 1 0 1", done, entry_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || entry_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got done=%b valid=%b busy=%b want 0 0 0", done, entry_valid, busy);
        end
    endtask

    task automatic test_cfg_conflict();
        entry_ready = 1'b1;
        cfg_valid = 1'b1; cfg_addr = 9'd5; cfg_data = 25'h55;
        start_walk(9'd0, 10'd2);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wr_en !== 1'b0 || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL conflict_busy%0d: got wr_en=%b cfg_ready=%b want 0 0", c, wr_en, cfg_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL conflict_idle: got cfg_ready=%b busy=%b want 1 0", cfg_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'd5 || wr_data !== 25'h55) begin
            errors++;
            $display("FAIL conflict_write: got en=%b addr=%0d data=%0h want 1 5 55", wr_en, wr_addr, wr_data);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        start_walk(9'd5, 10'd1);
        checks++;
        if (entry_valid !== 1'b1 || rd_q !== 25'h55 || entry_last !== 1'b1) begin
            errors++;
            $display("FAIL conflict_readback: got v=%b data=%0h last=%b want 1 55 1", entry_valid, rd_q, entry_last);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_walk();
        entry_ready = 1'b1;
        start_walk(9'd0, 10'd6);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (entry_index !== 10'd2 || entry_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got idx=%0d v=%b want 2 1", entry_index, entry_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, entry_valid, entry_last, wr_en} !== 5'b0 || entry_index !== '0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b done=%b valid=%b last=%b wr_en=%b idx=%0d want all 0",
                     busy, done, entry_valid, entry_last, wr_en, entry_index);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || entry_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet%0d: got done=%b valid=%b busy=%b want 0 0 0", c, done, entry_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_basic_walk();
        test_stall();
        test_wrap();
        test_zero_count();
        test_cfg_conflict();
        test_reset_mid_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
